// File: rtl/serial_deser_sync.sv
// rtl/serial_deser_sync.sv - serial deserializer with sync-word hunt, payload capture and optional parity
// Optional even-parity bit after the payload is enabled by defining DESER_PARITY_EN.
module serial_deser_sync #(
    parameter int unsigned       DATA_W    = 10,
    parameter int unsigned       SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1011,
    parameter bit                LSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inputdata_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              locked_o,
    output logic [7:0]        frame_cnt_o,
    output logic              parity_err_o
);

    localparam int unsigned FILL_W = $clog2(SYNC_W);
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_PARITY} state_t;
`else
    typedef enum logic [0:0] {ST_HUNT, ST_DATA} state_t;
`endif

    state_t              state_q, state_d;
    logic [SYNC_W-1:0]   win_q, win_d;
    logic [SYNC_W-1:0]   candidate;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic [7:0]          frame_cnt_q;

    // Window keeps the newest bit at the top, so index 0 is the oldest in arrival order.
    assign candidate = {inputdata_i, win_q[SYNC_W-1:1]};

`ifdef DESER_PARITY_EN
    logic perr_pend_q, perr_pend_d, perr_q;
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef DESER_PARITY_EN
        perr_pend_d = 1'b0;
`endif
        if (en_i) begin
            case (state_q)
                ST_HUNT: begin
                    win_d = candidate;
                    if (fill_q < FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                    if ((fill_q >= FILL_MAX) && (candidate == SYNC_PAT)) begin
                        state_d = ST_DATA;
                        win_d   = '0;
                        fill_d  = '0;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (LSB_FIRST) begin
                        shift_d = {inputdata_i, shift_q[DATA_W-1:1]};
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], inputdata_i};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
`ifdef DESER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_HUNT;
                        done_d  = 1'b1;
                        win_d   = '0;
                        fill_d  = '0;
`endif
                    end
                end
`ifdef DESER_PARITY_EN
                ST_PARITY: begin
                    state_d     = ST_HUNT;
                    done_d      = 1'b1;
                    perr_pend_d = (^shift_q) ^ inputdata_i;
                    win_d       = '0;
                    fill_d      = '0;
                end
`endif
                default: begin
                    state_d = ST_HUNT;
                    win_d   = '0;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HUNT;
            win_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Output stage runs one clock behind the final bit and ignores en_i, so valid_o is always one cycle wide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            done_q  <= done_d;
            valid_q <= done_q;
            if (done_q) begin
                data_q      <= shift_q;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            perr_pend_q <= perr_pend_d;
            perr_q      <= done_q & perr_pend_q;
        end
    end
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_cnt_o = frame_cnt_q;
    assign locked_o    = (state_q != ST_HUNT);

endmodule
